// File: rtl/mem_byte_sequencer.sv
// Byte-serial load/store sequencer for an 8-bit asynchronous-read memory.
// Splits byte/half/word requests into single-byte accesses.
module mem_byte_sequencer #(
    parameter int AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [7:0]        mem_d,
    output logic              mem_wen,
    output logic              mem_wbe,
    input  logic [7:0]        mem_q
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e            state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [AWIDTH-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        k_q;
    logic [31:0]       buf_q;
    logic              err_q;

    logic              err_d;
    logic [1:0]        last_d;
    logic [31:0]       rdata_d;

    // Alignment / size legality of the request being offered
    always_comb begin
        err_d = 1'b0;
        unique case (req_size)
            2'd0: err_d = 1'b0;
            2'd1: err_d = req_addr[0];
            2'd2: err_d = |req_addr[1:0];
            2'd3: err_d = 1'b1;
        endcase
    end

    // Index of the final byte: 0, 1 or 3 for byte, half, word
    assign last_d = {size_q[1], size_q[1] | size_q[0]};

    // Sequencer: accept, step through bytes, hold response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            k_q     <= 2'd0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        k_q     <= 2'd0;
                        buf_q   <= '0;
                        err_q   <= err_d;
                        state_q <= err_d ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        buf_q[{k_q, 3'b000} +: 8] <= mem_q;
                    end
                    if (k_q == last_d) begin
                        state_q <= RESP;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Assemble load data with optional sign extension
    always_comb begin
        rdata_d = '0;
        if (state_q == RESP && !we_q && !err_q) begin
            unique case (size_q)
                2'd0: rdata_d = {{24{sgn_q & buf_q[7]}}, buf_q[7:0]};
                2'd1: rdata_d = {{16{sgn_q & buf_q[15]}}, buf_q[15:0]};
                default: rdata_d = buf_q;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) && err_q;
        rsp_rdata = rdata_d;
        mem_addr  = '0;
        mem_d     = '0;
        mem_wen   = 1'b0;
        mem_wbe   = 1'b0;
        if (state_q == ACCESS) begin
            mem_addr = addr_q + {{(AWIDTH-2){1'b0}}, k_q};
            mem_wen  = we_q;
            mem_wbe  = we_q;
            if (we_q) begin
                mem_d = wdata_q[{k_q, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: doc/mem_byte_sequencer.md
MEM_BYTE_SEQUENCER -- requirements
Module: mem_byte_sequencer

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 14, giving the byte address width of the attached memory port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  access request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 req_signed  input  1  sign-extend byte/half load data.
REQ-009 req_addr  input  AWIDTH  byte address.
REQ-010 req_wdata  input  32  store data, little-endian.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned or illegal-size request.
REQ-015 mem_addr  output  AWIDTH  memory byte address.
REQ-016 mem_d  output  8  memory write data.
REQ-017 mem_wen  output  1  memory write enable.
REQ-018 mem_wbe  output  1  memory byte write enable.
REQ-019 mem_q  input  8  memory read data, valid combinationally from mem_addr (asynchronous read).

Function
REQ-020 FSM states SHALL be IDLE, ACCESS and RESP; req_ready=1 only in IDLE.
REQ-021 A request SHALL be accepted on an edge with req_valid=1 and req_ready=1, registering we, size, signed, addr and wdata.
REQ-022 An error SHALL be flagged for size=3, for size=1 with addr[0]=1, and for size=2 with addr[1:0]!=0; the request then goes IDLE->RESP directly with rsp_err=1, rsp_rdata=0 and no memory access.
REQ-023 A legal request SHALL go IDLE->ACCESS with byte counter k=0; n = 1, 2 or 4 bytes for size 0, 1 or 2.
REQ-024 In ACCESS, byte k SHALL be issued for exactly one cycle with mem_addr = (base + k) mod 2^AWIDTH.
REQ-025 For stores, mem_wen=1, mem_wbe=1 and mem_d = wdata[8k+7:8k] SHALL be driven during each ACCESS cycle.
REQ-026 For loads, mem_wen=0 and mem_wbe=0 SHALL be driven, and mem_q SHALL be captured into buffer byte k at the end of that cycle.
REQ-027 ACCESS SHALL last exactly n cycles; after byte n-1 the FSM SHALL go to RESP.
REQ-028 Outside ACCESS, mem_wen, mem_wbe, mem_d and mem_addr SHALL all be 0.
REQ-029 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until an edge with rsp_ready=1, after which the FSM goes to IDLE.
REQ-030 Load rsp_rdata SHALL be the assembled little-endian bytes.
REQ-031 For byte/half loads, the upper bits SHALL be replicated from bit 7/15 when signed=1, else zero.
REQ-032 Store rsp_rdata SHALL be 0 and rsp_err SHALL be 0.
REQ-033 Latency for a legal access, from accept edge to first rsp_valid cycle, SHALL be n+1 cycles; for an error it SHALL be 1 cycle.
REQ-034 A new request SHALL NOT be accepted in the same cycle a response completes; the earliest next accept is the cycle after return to IDLE.
REQ-035 req_* inputs SHALL be ignored outside IDLE; changes to them during ACCESS SHALL NOT affect the access in progress.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, k=0, the buffer to 0 and all registered request fields to 0.
REQ-037 During reset: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0 and all mem_* outputs=0.
REQ-038 Reset during ACCESS SHALL abort the access; store bytes already written remain in memory, and no response is produced.

Verification
REQ-039 Word store: addr=0x0010, wdata=0xA1B2C3D4, rsp_ready=1 -> mem writes 0xD4@0x10, 0xC3@0x11, 0xB2@0x12, 0xA1@0x13 on consecutive cycles; rsp_valid at accept+5, rsp_err=0.
REQ-040 Signed byte and half loads: memory holds 0x80 at 0x20 and 0x34,0xF2 at 0x22/0x23 -> signed byte load @0x20 returns 0xFFFFFF80; unsigned returns 0x00000080; signed half load @0x22 returns 0xFFFFF234.
REQ-041 Misalignment: half @0x0001 and word @0x0002 -> rsp_err=1, rsp_rdata=0 one cycle after accept, mem_wen never asserted; size=3 gives the same result.
REQ-042 Wrap-around: word load @0x3FFC with 0x3FFC..0x3FFF = 11,22,33,44 -> rsp_rdata=0x44332211, mem_addr sequence 0x3FFC..0x3FFF; half store @0x3FFE -> addresses 0x3FFE, 0x3FFF.
REQ-043 Backpressure: rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout; accept occurs the cycle after rsp_ready=1.
REQ-044 Reset mid-store: rst_n low after 2 of 4 word-store bytes -> outputs go to reset values immediately, only those 2 bytes are written, no rsp_valid, and the next request proceeds normally.
